rom_boot_loader: RTL
====================

Name: rom_boot_loader

Overview:
- Upstream stage of the computer's instruction ROM: receives a program image as a byte stream and writes it word-by-word into ROM.
- Holds the CPU in reset while loading; releases it once the image is complete.
- Replaces file-based ROM initialisation for bring-up and for bench-driven program loading.

Parameters:
- ADDR_W, 8, ROM address width; ROM depth = 2**ADDR_W words.
- WORD_W, 16, instruction word width; fixed at 2 bytes, high byte first.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle pulse: restart loading from DONE or ERR; ignored in other states.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a byte; transfer occurs when in_valid && in_ready at the clk rising edge.
- rom_we  out  1  ROM write strobe, one cycle per word.
- rom_addr  out  ADDR_W  ROM write address.
- rom_wdata  out  WORD_W  ROM write data.
- cpu_rst  out  1  reset to CPU; high while loading or in error.
- done  out  1  image loaded; CPU running.
- error  out  1  image rejected.

Behaviour:
- Async reset: state=LEN_HI, count=0, addr=0, word reg=0. Outputs: rom_we=0, rom_addr=0, rom_wdata=0, cpu_rst=1, done=0, error=0, in_ready=1.
- Image format: 2-byte word count N (big-endian), then N words, each high byte first.
- States and transitions:
  - LEN_HI: on transfer, latch N[15:8] -> LEN_LO.
  - LEN_LO: on transfer, latch N[7:0], then:
    - N==0 -> DONE (or CSUM if enabled).
    - N>2**ADDR_W -> ERR.
    - otherwise -> DATA_HI.
  - DATA_HI: on transfer, latch word[15:8] -> DATA_LO.
  - DATA_LO: on transfer, latch word[7:0] -> WRITE.
  - WRITE: exactly one cycle; rom_we=1, rom_addr=addr, rom_wdata=word; in_ready=0. Then addr+1, count+1; count==N -> DONE (or CSUM), else -> DATA_HI.
  - DONE: cpu_rst=0, done=1, in_ready=0. load pulse -> LEN_HI with addr=0, count=0, cpu_rst=1, done=0.
  - ERR: cpu_rst=1, error=1, in_ready=0. load pulse -> LEN_HI, clears error.
- in_ready: 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM; 0 otherwise.
- Throughput: one word per 3 cycles max; in_valid low stalls indefinitely with no state change.
- Latency: rom_we asserts the cycle after the low byte is accepted.
- Address: wraps only at N==2**ADDR_W, as the final write; never writes past depth.
- rom_addr and rom_wdata hold their last values when rom_we=0.
- Bytes presented while in_ready=0 are not consumed.
- load while receiving: ignored.
- rst asserted mid-image: immediate return to reset state. Partial ROM contents stay in ROM, but the CPU is held in reset.
- cpu_rst is registered; it deasserts the same cycle done asserts, with no glitch.

Optional Feature:
- Macro BOOT_CHECKSUM_EN.
- Defined:
  - A CSUM state follows the last WRITE (or LEN_LO when N==0) and accepts one trailing byte.
  - Running checksum = XOR of all bytes after the length field; cleared on reset and on load.
  - Trailing byte equal to the checksum -> DONE; otherwise -> ERR.
- Undefined: no CSUM state, no checksum register; the last WRITE goes directly to DONE.

Test Plan:
- Stream 00 02 12 34 AB CD -> rom_we pulses: addr0=0x1234, addr1=0xABCD. done=1 and cpu_rst=0 the cycle after the 2nd write; in_ready=0 thereafter.
- Stream 00 00 -> DONE with no rom_we pulse; cpu_rst falls after the 2nd byte. With BOOT_CHECKSUM_EN, an extra byte 00 is required first.
- ADDR_W=8, stream 01 01 -> error=1, cpu_rst=1, no writes. Then load pulse plus a valid image -> done=1.
- Random in_valid gaps (0–5 idle cycles) on a 4-word image -> identical ROM contents, no duplicate or dropped writes, rom_we never with in_ready=1.
- rst asserted after 3 words of a 5-word image -> all outputs return to reset values asynchronously. A full 5-word reload then writes addr0..4 correctly.
- BOOT_CHECKSUM_EN, stream 00 01 12 34 26 -> done=1. Same stream with trailing 27 -> error=1, cpu_rst stays 1.

Source files
------------

// File: rtl/rom_boot_loader.sv
// Streams a length-prefixed program image into instruction ROM, holding the CPU in reset until complete.
// Optional trailing XOR checksum byte is enabled with BOOT_CHECKSUM_EN.
module rom_boot_loader #(
   parameter int ADDR_W = 8,
   parameter int WORD_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              rom_we,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [WORD_W-1:0] rom_wdata,
   output logic              cpu_rst,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      S_LEN_HI,
      S_LEN_LO,
      S_DATA_HI,
      S_DATA_LO,
      S_WRITE,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

`ifdef BOOT_CHECKSUM_EN
   localparam state_t S_END = S_CSUM;
`else
   localparam state_t S_END = S_DONE;
`endif

   localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

   state_t              state_q, state_d;
   logic [15:0]         len_q, len_d;
   logic [15:0]         count_q, count_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [7:0]          hi_q, hi_d;
   logic [ADDR_W-1:0]   wa_q, wa_d;
   logic [WORD_W-1:0]   wd_q, wd_d;
   logic                cpu_rst_q;
   logic                xfer;
   logic [15:0]         n_full;
   logic [15:0]         count_inc;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]          csum_q, csum_d;
`endif

   assign in_ready = (state_q == S_LEN_HI)  || (state_q == S_LEN_LO)  ||
                     (state_q == S_DATA_HI) || (state_q == S_DATA_LO) ||
                     (state_q == S_CSUM);
   assign xfer      = in_valid && in_ready;
   assign n_full    = {len_q[15:8], in_data};
   assign count_inc = count_q + 16'd1;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      count_d = count_q;
      addr_d  = addr_q;
      hi_d    = hi_q;
      wa_d    = wa_q;
      wd_d    = wd_q;
      rom_we  = 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      unique case (state_q)
         S_LEN_HI: begin
            if (xfer) begin
               len_d[15:8] = in_data;
               state_d     = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (xfer) begin
               len_d[7:0] = in_data;
               if (n_full == 16'd0)
                  state_d = S_END;
               else if ({1'b0, n_full} > DEPTH)
                  state_d = S_ERR;
               else
                  state_d = S_DATA_HI;
            end
         end
         S_DATA_HI: begin
            if (xfer) begin
               hi_d    = in_data;
               state_d = S_DATA_LO;
`ifdef BOOT_CHECKSUM_EN
               csum_d  = csum_q ^ in_data;
`endif
            end
         end
         S_DATA_LO: begin
            if (xfer) begin
               // Separate output registers keep rom_addr/rom_wdata stable between writes
               wa_d    = addr_q;
               wd_d    = {hi_q, in_data};
               state_d = S_WRITE;
`ifdef BOOT_CHECKSUM_EN
               csum_d  = csum_q ^ in_data;
`endif
            end
         end
         S_WRITE: begin
            rom_we  = 1'b1;
            addr_d  = addr_q + 1'b1;
            count_d = count_inc;
            state_d = (count_inc == len_q) ? S_END : S_DATA_HI;
         end
`ifdef BOOT_CHECKSUM_EN
         S_CSUM: begin
            if (xfer)
               state_d = (in_data == csum_q) ? S_DONE : S_ERR;
         end
`endif
         S_DONE, S_ERR: begin
            if (load) begin
               state_d = S_LEN_HI;
               addr_d  = '0;
               count_d = '0;
`ifdef BOOT_CHECKSUM_EN
               csum_d  = '0;
`endif
            end
         end
         default: state_d = S_LEN_HI;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_LEN_HI;
         len_q     <= '0;
         count_q   <= '0;
         addr_q    <= '0;
         hi_q      <= '0;
         wa_q      <= '0;
         wd_q      <= '0;
         cpu_rst_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         count_q   <= count_d;
         addr_q    <= addr_d;
         hi_q      <= hi_d;
         wa_q      <= wa_d;
         wd_q      <= wd_d;
         cpu_rst_q <= (state_d != S_DONE);
      end
   end

`ifdef BOOT_CHECKSUM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         csum_q <= '0;
      else
         csum_q <= csum_d;
   end
`endif

   assign rom_addr  = wa_q;
   assign rom_wdata = wd_q;
   assign cpu_rst   = cpu_rst_q;
   assign done      = (state_q == S_DONE);
   assign error     = (state_q == S_ERR);

endmodule
